// File: rtl/code_lock_4_pkg.sv
// Shared definitions for the code_lock_4 digit lock.
// Holds the FSM state encoding and the default parameter values.
// No logic; imported by code_lock_4 and nibble_eq.
package code_lock_4_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_PROG   = 2'd2,
        ST_ALARM  = 2'd3
    } state_t;

    localparam int          DEF_NDIG       = 4;
    localparam int          DEF_MAX_FAIL   = 3;
    localparam int          DEF_ALARM_LEN  = 16;
    localparam logic [15:0] DEF_RESET_CODE = 16'h1234;

endpackage

// File: rtl/code_lock_4_nibble_eq.sv
// Purpose: exact 4-bit equality of an entered digit against a stored digit.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: i_a, i_b - digits to compare; o_eq - high when identical.
module nibble_eq
    import code_lock_4_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic       o_eq
);

    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/code_lock_4.sv
// Purpose: NDIG-digit code lock with programming mode and fail-count alarm.
// Latency: outputs registered; unlocked rises the cycle after the last correct digit.
// Backpressure: none; digit_vld is sampled every edge and ignored in OPEN/ALARM.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   digit, digit_vld    - entered digit and its qualifier
//   relock, prog        - level controls used in OPEN (relock also aborts PROG)
//   unlocked, alarm     - state indications (OPEN/PROG, ALARM)
//   fail_cnt, digit_idx - consecutive wrong entries, next digit position
module code_lock_4
    import code_lock_4_pkg::*;
#(
    parameter int                NDIG       = DEF_NDIG,
    parameter int                MAX_FAIL   = DEF_MAX_FAIL,
    parameter int                ALARM_LEN  = DEF_ALARM_LEN,
    parameter logic [NDIG*4-1:0] RESET_CODE = DEF_RESET_CODE
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit,
    input  logic       digit_vld,
    input  logic       relock,
    input  logic       prog,
    output logic       unlocked,
    output logic       alarm,
    output logic [1:0] fail_cnt,
    output logic [1:0] digit_idx
);

    localparam int               TW         = $clog2(ALARM_LEN + 1);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(ALARM_LEN - 1);
    localparam logic [1:0]       LAST_IDX   = 2'(NDIG - 1);
    // One bit wider than fail_cnt so a MAX_FAIL of 4 still compares correctly.
    localparam logic [2:0]       FAIL_LIMIT = 3'(MAX_FAIL);

    state_t              r_state;
    logic [NDIG*4-1:0]   r_code;
    logic [NDIG*4-1:0]   r_shadow;
    logic [1:0]          r_idx;
    logic [1:0]          r_fail;
    logic                r_mis;
    logic                r_unlocked;
    logic                r_alarm;
    logic [TW-1:0]       r_timer;

    logic [3:0]          w_code_dig;
    logic                w_eq;
    logic                w_mis_now;
    logic [2:0]          w_fail_inc;
    logic [NDIG*4-1:0]   w_prog_code;

    assign w_code_dig = r_code[r_idx*4 +: 4];

    nibble_eq u_nibble_eq (
        .i_a  (digit),
        .i_b  (w_code_dig),
        .o_eq (w_eq)
    );

    // Mismatch including the digit being accepted this edge.
    assign w_mis_now  = r_mis | ~w_eq;
    assign w_fail_inc = {1'b0, r_fail} + 3'd1;

    // Shadow with the current digit merged in; used both to update the shadow
    // and, on the final digit, as the complete new code committed in one edge.
    always_comb begin
        w_prog_code = r_shadow;
        w_prog_code[r_idx*4 +: 4] = digit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_LOCKED;
            r_code     <= RESET_CODE;
            r_shadow   <= '0;
            r_idx      <= 2'd0;
            r_fail     <= 2'd0;
            r_mis      <= 1'b0;
            r_unlocked <= 1'b0;
            r_alarm    <= 1'b0;
            r_timer    <= '0;
        end else begin
            case (r_state)
                ST_LOCKED: begin
                    if (digit_vld) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx <= 2'd0;
                            r_mis <= 1'b0;
                            if (!w_mis_now) begin
                                r_state    <= ST_OPEN;
                                r_unlocked <= 1'b1;
                                r_fail     <= 2'd0;
                            end else if (w_fail_inc == FAIL_LIMIT) begin
                                r_state <= ST_ALARM;
                                r_alarm <= 1'b1;
                                r_fail  <= 2'd0;
                                r_timer <= '0;
                            end else begin
                                r_fail <= w_fail_inc[1:0];
                            end
                        end else begin
                            r_idx <= r_idx + 2'd1;
                            r_mis <= w_mis_now;
                        end
                    end
                end

                ST_OPEN: begin
                    // relock has priority over prog.
                    if (relock) begin
                        r_state    <= ST_LOCKED;
                        r_unlocked <= 1'b0;
                        r_idx      <= 2'd0;
                        r_mis      <= 1'b0;
                    end else if (prog) begin
                        r_state  <= ST_PROG;
                        r_shadow <= '0;
                        r_idx    <= 2'd0;
                    end
                end

                ST_PROG: begin
                    // relock aborts programming; the stored code is untouched.
                    if (relock) begin
                        r_state    <= ST_LOCKED;
                        r_unlocked <= 1'b0;
                        r_shadow   <= '0;
                        r_idx      <= 2'd0;
                        r_mis      <= 1'b0;
                    end else if (digit_vld) begin
                        if (r_idx == LAST_IDX) begin
                            r_code   <= w_prog_code;
                            r_shadow <= '0;
                            r_state  <= ST_OPEN;
                            r_idx    <= 2'd0;
                        end else begin
                            r_shadow <= w_prog_code;
                            r_idx    <= r_idx + 2'd1;
                        end
                    end
                end

                ST_ALARM: begin
                    // Timer counts edges spent in ALARM; exit after ALARM_LEN cycles.
                    if (r_timer == TIMER_LAST) begin
                        r_state <= ST_LOCKED;
                        r_alarm <= 1'b0;
                        r_idx   <= 2'd0;
                        r_mis   <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                default: begin
                    r_state    <= ST_LOCKED;
                    r_unlocked <= 1'b0;
                    r_alarm    <= 1'b0;
                    r_idx      <= 2'd0;
                end
            endcase
        end
    end

    assign unlocked  = r_unlocked;
    assign alarm     = r_alarm;
    assign fail_cnt  = r_fail;
    assign digit_idx = r_idx;

endmodule

// File: tb/tb_code_lock_4.sv
module tb_code_lock_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       digit_vld = 1'b0;
    logic       relock = 1'b0;
    logic       prog = 1'b0;
    logic       unlocked;
    logic       alarm;
    logic [1:0] fail_cnt;
    logic [1:0] digit_idx;

    always #5 clk = ~clk;

    code_lock_4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit     (digit),
        .digit_vld (digit_vld),
        .relock    (relock),
        .prog      (prog),
        .unlocked  (unlocked),
        .alarm     (alarm),
        .fail_cnt  (fail_cnt),
        .digit_idx (digit_idx)
    );

    typedef struct {
        logic       vld;
        logic [3:0] dig;
        logic       rel;
        logic       prg;
        logic       u;
        logic       a;
        logic [1:0] f;
        logic [1:0] i;
    } vec_t;

    typedef struct packed {
        logic       u;
        logic       a;
        logic [1:0] f;
        logic [1:0] i;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic vld, input logic [3:0] dig, input logic rel,
                       input logic prg, input logic u, input logic a,
                       input logic [1:0] f, input logic [1:0] i);
        vec_t v;
        v.vld = vld; v.dig = dig; v.rel = rel; v.prg = prg;
        v.u = u; v.a = a; v.f = f; v.i = i;
        tbl.push_back(v);
    endtask

    // Four digits from LOCKED: three intermediate steps, then the final outcome.
    task automatic add_entry(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3,
                             input logic [1:0] f_pre, input logic u_end,
                             input logic a_end, input logic [1:0] f_end);
        add(1'b1, d0, 1'b0, 1'b0, 1'b0, 1'b0, f_pre, 2'd1);
        add(1'b1, d1, 1'b0, 1'b0, 1'b0, 1'b0, f_pre, 2'd2);
        add(1'b1, d2, 1'b0, 1'b0, 1'b0, 1'b0, f_pre, 2'd3);
        add(1'b1, d3, 1'b0, 1'b0, u_end, a_end, f_end, 2'd0);
    endtask

    // Called at a falling edge: drive, push expectation, let one rising edge
    // pass, pop and compare at the next falling edge.
    task automatic step(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        digit_vld = v.vld; digit = v.dig; relock = v.rel; prog = v.prg;
        e.u = v.u; e.a = v.a; e.f = v.f; e.i = v.i;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = {unlocked, alarm, fail_cnt, digit_idx};
        e = sbq.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: got u=%0b a=%0b f=%0d i=%0d, expected u=%0b a=%0b f=%0d i=%0d",
                     name, got.u, got.a, got.f, got.i, e.u, e.a, e.f, e.i);
        end
        digit_vld = 1'b0; relock = 1'b0; prog = 1'b0;
    endtask

    task automatic run_table(input string name);
        for (int k = 0; k < tbl.size(); k++)
            step(tbl[k], $sformatf("%s[%0d]", name, k));
        tbl.delete();
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({unlocked, alarm, fail_cnt, digit_idx} !== 6'd0) begin
            failures++;
            $display("FAIL %s: got u=%0b a=%0b f=%0d i=%0d, expected all zero",
                     name, unlocked, alarm, fail_cnt, digit_idx);
        end
    endtask

    // Asynchronous reset pulse mid-low-phase; outputs must clear before any edge.
    task automatic rst_pulse(input string name);
        #2 rst_n = 1'b0;
        #1 check_zero(name);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 check_zero("reset_state");
        @(negedge clk);
        check_zero("reset_hold");
        rst_n = 1'b1;

        // Correct code, ignored digit in OPEN, relock-beats-prog, partial
        // entry retained across idle cycles, then three wrong entries.
        add_entry(4'h4, 4'h3, 4'h2, 4'h1, 2'd0, 1'b1, 1'b0, 2'd0);
        add(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        add(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        add(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
        add(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
        add(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
        add(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
        add(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
        add(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        add(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        add_entry(4'h4, 4'h3, 4'h2, 4'h0, 2'd0, 1'b0, 1'b0, 2'd1);
        add_entry(4'h0, 4'h3, 4'h2, 4'h1, 2'd1, 1'b0, 1'b0, 2'd2);
        add_entry(4'h4, 4'h3, 4'h2, 4'h0, 2'd2, 1'b0, 1'b1, 2'd0);
        run_table("basic");

        // Alarm lasts 16 cycles in total; the entry step above was the first.
        // Inputs toggle throughout and must have no effect.
        for (int k = 0; k < 15; k++) begin
            vec_t v;
            v.vld = 1'b1; v.dig = 4'(4 - (k % 4)); v.rel = k[0]; v.prg = k[1];
            v.u = 1'b0; v.a = 1'b1; v.f = 2'd0; v.i = 2'd0;
            step(v, $sformatf("alarm_hold[%0d]", k));
        end
        add(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        add_entry(4'h4, 4'h3, 4'h2, 4'h1, 2'd0, 1'b1, 1'b0, 2'd0);
        run_table("alarm_exit");

        // Program D,C,B,A (code becomes 16'hABCD, digit 0 = D), relock,
        // the same sequence unlocks, the old code now counts as a failure.
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
        add(1'b1, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1);
        add(1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2);
        add(1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3);
        add(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        add(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        add_entry(4'hD, 4'hC, 4'hB, 4'hA, 2'd0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        add_entry(4'h4, 4'h3, 4'h2, 4'h1, 2'd0, 1'b0, 1'b0, 2'd1);
        add(1'b1, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1);
        add(1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2);
        run_table("program");

        // Reset mid-entry: programmed code must not survive.
        rst_pulse("reset_mid_entry");
        add_entry(4'h4, 4'h3, 4'h2, 4'h1, 2'd0, 1'b1, 1'b0, 2'd0);
        // Aborted programming (relock wins over a simultaneous digit).
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
        add(1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1);
        add(1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2);
        add(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        add_entry(4'h4, 4'h3, 4'h2, 4'h1, 2'd0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        add_entry(4'hF, 4'h3, 4'h2, 4'h1, 2'd0, 1'b0, 1'b0, 2'd1);
        add_entry(4'h4, 4'h3, 4'hF, 4'h1, 2'd1, 1'b0, 1'b0, 2'd2);
        add_entry(4'h4, 4'h3, 4'h2, 4'hF, 2'd2, 1'b0, 1'b1, 2'd0);
        add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        run_table("abort_prog");

        // Reset mid-alarm, then a fresh unlock.
        rst_pulse("reset_mid_alarm");
        add_entry(4'h4, 4'h3, 4'h2, 4'h1, 2'd0, 1'b1, 1'b0, 2'd0);
        run_table("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
